// File: rtl/spram_pkg.sv
// ---------------------------------------------------------------------------
// spram_pkg : shared types and derivation helpers for the single-port RAM
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package spram_pkg;

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_IDLE = 1'b1
  } state_e;

  localparam int unsigned c_default_init_value = 0;

  function automatic int spram_addr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int spram_lanes(input int width, input int byte_w);
    return width / byte_w;
  endfunction

endpackage

`default_nettype wire

// File: rtl/spram_core.sv
// ---------------------------------------------------------------------------
// spram_core : storage array with byte-lane write and registered read
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spram_core
  import spram_pkg::*;
#(
  parameter  int WIDTH  = 32,
  parameter  int DEPTH  = 16,
  parameter  int BYTE_W = 8,
  localparam int NB     = spram_lanes(WIDTH, BYTE_W),
  localparam int ADDR_W = spram_addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              we,
  input  logic [NB-1:0]     be,
  input  logic [ADDR_W-1:0] address,
  input  logic [WIDTH-1:0]  data,
  output logic [WIDTH-1:0]  q
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             w_in_range;

  // Non-power-of-two depths leave a hole in the address space that must never index the array
  assign w_in_range = 32'(address) < DEPTH;

  always_ff @(posedge clock) begin
    if (we && w_in_range) begin
      for (int i = 0; i < NB; i++) begin
        if (be[i]) begin
          mem_q[address][i*BYTE_W +: BYTE_W] <= data[i*BYTE_W +: BYTE_W];
        end
      end
    end
    q <= w_in_range ? mem_q[address] : '0;
  end

endmodule

`default_nettype wire

// File: rtl/single_port_ram_ctrl.sv
// ---------------------------------------------------------------------------
// single_port_ram_ctrl : valid/ready RAM controller with hardware clear engine
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module single_port_ram_ctrl
  import spram_pkg::*;
#(
  parameter  int               WIDTH      = 32,
  parameter  int               DEPTH      = 16,
  parameter  int               BYTE_W     = 8,
  parameter  logic [WIDTH-1:0] INIT_VALUE = WIDTH'(c_default_init_value),
  localparam int               NB         = spram_lanes(WIDTH, BYTE_W),
  localparam int               ADDR_W     = spram_addr_w(DEPTH)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              clear,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [NB-1:0]     req_be,
  input  logic [ADDR_W-1:0] req_address,
  input  logic [WIDTH-1:0]  req_data,
  output logic              rsp_valid,
  output logic [WIDTH-1:0]  rsp_data,
  output logic              rsp_err,
  output logic              init_done
);

  localparam logic [ADDR_W-1:0] c_last = ADDR_W'(DEPTH - 1);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [WIDTH-1:0]  rsp_hold_q;

  logic              w_accept;
  logic              w_addr_ok;
  logic              w_core_we;
  logic [NB-1:0]     w_core_be;
  logic [ADDR_W-1:0] w_core_addr;
  logic [WIDTH-1:0]  w_core_data;
  logic [WIDTH-1:0]  w_core_q;

  assign w_accept  = req_valid && (state_q == ST_IDLE) && !clear;
  assign w_addr_ok = 32'(req_address) < DEPTH;

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= ST_INIT;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_hold_q  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      if (rsp_valid_q) begin
        rsp_hold_q <= rsp_data;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_INIT: begin
        if (cnt_q == c_last) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end
      ST_IDLE: begin
        if (clear) begin
          state_d = ST_INIT;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    req_ready   = 1'b0;
    init_done   = 1'b0;
    w_core_we   = 1'b0;
    w_core_be   = '0;
    w_core_addr = '0;
    w_core_data = '0;
    rsp_valid_d = 1'b0;
    rsp_err_d   = 1'b0;
    case (state_q)
      ST_INIT: begin
        w_core_we   = 1'b1;
        w_core_be   = '1;
        w_core_addr = cnt_q;
        w_core_data = INIT_VALUE;
      end
      ST_IDLE: begin
        req_ready   = !clear;
        init_done   = 1'b1;
        w_core_be   = req_be;
        w_core_addr = req_address;
        w_core_data = req_data;
        w_core_we   = w_accept && req_we && w_addr_ok;
        rsp_valid_d = w_accept && !req_we;
        rsp_err_d   = w_accept && !req_we && !w_addr_ok;
      end
      default: ;
    endcase
  end

  // Read data arrives with rsp_valid; between responses the last delivered word is held
  assign rsp_valid = rsp_valid_q;
  assign rsp_err   = rsp_err_q;
  assign rsp_data  = rsp_valid_q ? (rsp_err_q ? '0 : w_core_q) : rsp_hold_q;

  spram_core #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .BYTE_W (BYTE_W)
  ) u_core (
    .clock   (clock),
    .we      (w_core_we),
    .be      (w_core_be),
    .address (w_core_addr),
    .data    (w_core_data),
    .q       (w_core_q)
  );

endmodule

`default_nettype wire

// File: tb/tb_single_port_ram_ctrl.sv
// ---------------------------------------------------------------------------
// tb_single_port_ram_ctrl : self-checking bench for single_port_ram_ctrl
// Rev 1.0
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
`default_nettype none

module tb_single_port_ram_ctrl;

  localparam int D = 16;
  localparam logic [31:0] c_init = 32'h0;

  logic        clock = 1'b0;
  always #5 clock = ~clock;

  logic        reset_n, clear, req_valid, req_we, req_ready;
  logic [3:0]  req_be, req_address;
  logic [31:0] req_data, rsp_data;
  logic        rsp_valid, rsp_err, init_done;

  logic        b_reset_n, b_clear, b_req_valid, b_req_we, b_req_ready;
  logic [3:0]  b_req_be, b_req_address;
  logic [31:0] b_req_data, b_rsp_data;
  logic        b_rsp_valid, b_rsp_err, b_init_done;

  single_port_ram_ctrl #(.WIDTH(32), .DEPTH(16), .BYTE_W(8), .INIT_VALUE(c_init)) dut (
    .clock(clock), .reset_n(reset_n), .clear(clear), .req_valid(req_valid),
    .req_ready(req_ready), .req_we(req_we), .req_be(req_be), .req_address(req_address),
    .req_data(req_data), .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .init_done(init_done)
  );

  single_port_ram_ctrl #(.WIDTH(32), .DEPTH(10), .BYTE_W(8), .INIT_VALUE(c_init)) dut_b (
    .clock(clock), .reset_n(b_reset_n), .clear(b_clear), .req_valid(b_req_valid),
    .req_ready(b_req_ready), .req_we(b_req_we), .req_be(b_req_be), .req_address(b_req_address),
    .req_data(b_req_data), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
    .init_done(b_init_done)
  );

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [3:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] model [D];
  logic [31:0] last_rsp = 32'h0;
  vec_t        vecs [11];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clock);
    #1;
  endtask

  function automatic logic [31:0] lane_mask(input logic [3:0] be);
    return {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < D; i++) model[i] = c_init;
  endtask

  task automatic do_req(input logic we, input logic [3:0] be, input logic [3:0] addr,
                        input logic [31:0] data, input logic [31:0] exp);
    logic [31:0] m;
    req_valid = 1'b1; req_we = we; req_be = be; req_address = addr; req_data = data;
    #1;
    check("req_ready", req_ready, 1'b1);
    cycle();
    if (we) begin
      m = lane_mask(be);
      model[addr] = (model[addr] & ~m) | (data & m);
      check("rsp_valid_after_write", rsp_valid, 1'b0);
    end else begin
      check("rsp_valid", rsp_valid, 1'b1);
      check("rsp_data", rsp_data, exp);
      check("rsp_err", rsp_err, 1'b0);
      last_rsp = exp;
    end
  endtask

  // Counts cycles with init_done low, starting right after the edge that entered INIT
  task automatic wait_init(input int exp_cycles);
    int n;
    bit ready_seen, rsp_seen;
    n = 0; ready_seen = 0; rsp_seen = 0;
    while (!init_done && n < 200) begin
      if (req_ready) ready_seen = 1;
      if (rsp_valid) rsp_seen = 1;
      n++;
      cycle();
    end
    check("init_cycles", n, exp_cycles);
    check("ready_during_init", ready_seen, 1'b0);
    check("rsp_during_init", rsp_seen, 1'b0);
  endtask

  task automatic b_req(input logic we, input logic [3:0] be, input logic [3:0] addr,
                       input logic [31:0] data);
    b_req_valid = 1'b1; b_req_we = we; b_req_be = be; b_req_address = addr; b_req_data = data;
    #1;
    check("b_req_ready", b_req_ready, 1'b1);
    cycle();
    b_req_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic        r_we;
    logic [3:0]  r_be, r_a;
    logic [31:0] r_d;
    int          n;

    reset_n = 0; clear = 0; req_valid = 0; req_we = 0; req_be = 0; req_address = 0; req_data = 0;
    b_reset_n = 0; b_clear = 0; b_req_valid = 0; b_req_we = 0; b_req_be = 0;
    b_req_address = 0; b_req_data = 0;
    model_clear();
    repeat (3) cycle();

    check("reset_req_ready", req_ready, 1'b0);
    check("reset_rsp_valid", rsp_valid, 1'b0);
    check("reset_rsp_err", rsp_err, 1'b0);
    check("reset_rsp_data", rsp_data, 32'h0);
    check("reset_init_done", init_done, 1'b0);

    // Release reset with a read pending; it must wait for IDLE
    reset_n = 1;
    req_valid = 1; req_we = 0; req_address = 4'd2;
    wait_init(16);
    for (int a = 0; a < D; a++) do_req(1'b0, 4'h0, 4'(a), 32'h0, c_init);

    vecs[0]  = '{1'b1, 4'hF, 4'd3,  32'hDEADBEEF, 32'h0};
    vecs[1]  = '{1'b1, 4'h1, 4'd3,  32'h000000AA, 32'h0};
    vecs[2]  = '{1'b0, 4'h0, 4'd3,  32'h0,        32'hDEADBEAA};
    vecs[3]  = '{1'b1, 4'h6, 4'd7,  32'h11223344, 32'h0};
    vecs[4]  = '{1'b0, 4'h0, 4'd7,  32'h0,        32'h00223300};
    vecs[5]  = '{1'b1, 4'h0, 4'd7,  32'hFFFFFFFF, 32'h0};
    vecs[6]  = '{1'b0, 4'h0, 4'd7,  32'h0,        32'h00223300};
    vecs[7]  = '{1'b1, 4'h8, 4'd15, 32'hA5A5A5A5, 32'h0};
    vecs[8]  = '{1'b0, 4'h0, 4'd15, 32'h0,        32'hA5000000};
    vecs[9]  = '{1'b1, 4'hF, 4'd0,  32'hCAFEF00D, 32'h0};
    vecs[10] = '{1'b0, 4'h0, 4'd0,  32'h0,        32'hCAFEF00D};
    for (int i = 0; i < 11; i++) do_req(vecs[i].we, vecs[i].be, vecs[i].addr, vecs[i].data, vecs[i].exp);

    req_valid = 0;
    cycle();
    check("idle_rsp_valid", rsp_valid, 1'b0);
    check("idle_rsp_hold", rsp_data, 32'hCAFEF00D);

    for (int a = 0; a < D; a++) do_req(1'b1, 4'hF, 4'(a), 32'(a) * 32'h01010101, 32'h0);
    for (int a = 0; a < D; a++) do_req(1'b0, 4'h0, 4'(a), 32'h0, 32'(a) * 32'h01010101);

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(3) == 0) begin
        req_valid = 0;
        req_we = 1'($urandom_range(1));
        cycle();
        check("rand_idle_valid", rsp_valid, 1'b0);
        check("rand_idle_hold", rsp_data, last_rsp);
      end else begin
        r_we = 1'($urandom_range(1));
        r_be = 4'($urandom_range(15));
        r_a  = 4'($urandom_range(15));
        r_d  = $urandom;
        do_req(r_we, r_be, r_a, r_d, model[r_a]);
      end
    end

    // Clear arriving together with a read: read is held off until the clear completes
    req_valid = 1; req_we = 0; req_address = 4'd5; clear = 1;
    #1;
    check("clear_blocks_ready", req_ready, 1'b0);
    cycle();
    clear = 0;
    check("clear_no_rsp", rsp_valid, 1'b0);
    check("clear_init_done_low", init_done, 1'b0);
    wait_init(16);
    model_clear();
    do_req(1'b0, 4'h0, 4'd5, 32'h0, c_init);

    for (int a = 0; a < 4; a++) do_req(1'b1, 4'hF, 4'(a), 32'h5A5A0000 + 32'(a), 32'h0);
    do_req(1'b0, 4'h0, 4'd1, 32'h0, model[1]);
    // Reset in the same cycle as an accepted read drops the response
    req_valid = 1; req_we = 0; req_address = 4'd1; reset_n = 0;
    cycle();
    check("reset_drops_rsp", rsp_valid, 1'b0);
    check("reset_drops_init_done", init_done, 1'b0);
    reset_n = 1;
    repeat (7) cycle();
    check("mid_init_done_low", init_done, 1'b0);
    reset_n = 0;
    cycle();
    reset_n = 1;
    wait_init(16);
    model_clear();
    for (int a = 0; a < D; a++) do_req(1'b0, 4'h0, 4'(a), 32'h0, c_init);
    req_valid = 0;

    b_reset_n = 0;
    cycle();
    b_reset_n = 1;
    n = 0;
    while (!b_init_done && n < 200) begin
      n++;
      cycle();
    end
    check("b_init_cycles", n, 10);
    b_req(1'b1, 4'hF, 4'd12, 32'h00000055);
    check("b_write_oob_no_rsp", b_rsp_valid, 1'b0);
    b_req(1'b0, 4'h0, 4'd12, 32'h0);
    check("b_oob_valid", b_rsp_valid, 1'b1);
    check("b_oob_data", b_rsp_data, 32'h0);
    check("b_oob_err", b_rsp_err, 1'b1);
    b_req(1'b0, 4'h0, 4'd9, 32'h0);
    check("b_last_valid", b_rsp_valid, 1'b1);
    check("b_last_data", b_rsp_data, 32'h0);
    check("b_last_err", b_rsp_err, 1'b0);
    b_req(1'b1, 4'hF, 4'd9, 32'h12345678);
    b_req(1'b0, 4'h0, 4'd9, 32'h0);
    check("b_rw_data", b_rsp_data, 32'h12345678);
    check("b_rw_err", b_rsp_err, 1'b0);
    cycle();
    check("b_idle_valid", b_rsp_valid, 1'b0);
    check("b_idle_err", b_rsp_err, 1'b0);
    check("b_idle_hold", b_rsp_data, 32'h12345678);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/single_port_ram_ctrl.md
Name: single_port_ram_ctrl

Overview:
Parametrised successor to the team's single-port RAM.
- Adds a registered read port, per-byte write enables and a valid/ready request handshake.
- Adds a hardware clear engine that fills memory with INIT_VALUE after reset or on demand, replacing simulation-only initialisation.
- Sits between a bus master or datapath and on-chip storage; one request per cycle, single port.

Parameters:
WIDTH, 32, data word width in bits; must be a multiple of BYTE_W
DEPTH, 16, number of words; need not be a power of two
BYTE_W, 8, bits per write-enable lane; lanes NB = WIDTH/BYTE_W
INIT_VALUE, 0, word value written to every location by the clear engine
ADDR_W, max(1,$clog2(DEPTH)), address width (derived; not overridden)

Ports:
clock  in  1  rising-edge clock
reset_n  in  1  synchronous active-low reset, sampled on rising edge of clock
clear  in  1  request a full memory clear; level, sampled in IDLE only
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_we  in  1  1 = write, 0 = read
req_be  in  NB  byte-lane write enables (writes only)
req_address  in  ADDR_W  word address
req_data  in  WIDTH  write data
rsp_valid  out  1  read data valid, single-cycle pulse
rsp_data  out  WIDTH  read data
rsp_err  out  1  qualifies rsp_valid: read address was >= DEPTH
init_done  out  1  high when memory contents are fully cleared and block is IDLE

Behaviour:
Reset values (reset_n low at a clock edge): state=INIT, clear counter=0, req_ready=0, rsp_valid=0, rsp_err=0, rsp_data=0, init_done=0. Memory contents are not reset directly; the INIT sequence clears them.

States: INIT, IDLE.
- INIT: each cycle writes INIT_VALUE to address cnt; cnt increments.
  - When cnt==DEPTH-1 is written, the next state is IDLE.
  - Takes exactly DEPTH cycles; init_done rises on the first IDLE cycle.
  - req_ready=0 throughout; clear is ignored.
- IDLE: req_ready = !clear (combinational on clear only; not on req_valid).
  - clear=1 in IDLE: next state INIT, cnt=0, init_done falls next cycle. A request presented in the same cycle is not accepted and must be held by the master.
- Reset asserted mid-INIT or mid-IDLE: restarts INIT at address 0 and drops any pending response.

Accepted write (IDLE, handshake, req_we=1):
- For each lane i with req_be[i]=1, store bits [i*BYTE_W +: BYTE_W] of req_data at the clock edge; other lanes are unchanged.
- req_be=0 is a legal no-op.
- No response.

Accepted read (req_we=0):
- rsp_valid=1 exactly one cycle later, with rsp_data = stored word at acceptance.
- Back-to-back reads give one response per cycle, in order.
- rsp_valid is low in all other cycles; rsp_data holds its last value when rsp_valid=0.

Read after write, same address, consecutive cycles: the read returns the newly written data (write completes at the edge that accepts it).

Address >= DEPTH (only possible when DEPTH is not a power of two):
- Write: discarded.
- Read: rsp_valid=1, rsp_data=0, rsp_err=1.
- rsp_err is otherwise 0.

No response backpressure: the consumer must always take rsp_valid.

Full throughput: one request per cycle in IDLE, indefinitely.

Decomposition:
- Package spram_pkg: state enum (INIT, IDLE), helper function for NB/ADDR_W derivation, a default INIT_VALUE constant.
- One sub-module, spram_core: storage array with byte-lane write and registered read. Ports: clock, we, be, address, data, q.
- The controller (FSM, clear counter, mux of clear vs request address/data, range check, rsp_valid/rsp_err regs) lives in single_port_ram_ctrl.

Test Plan:
- Reset, DEPTH=16 -> init_done low for exactly 16 cycles after reset release, req_ready=0 throughout; then read all 16 addresses -> each returns INIT_VALUE (0), rsp_valid exactly 1 cycle after each accept.
- Write 0xDEADBEEF to addr 3 with be=4'b1111, then write 0x000000AA with be=4'b0001, then read addr 3 -> rsp_data=0xDEADBEAA.
- Back-to-back: writes to addr 0..15 with data=addr*0x01010101, then 16 consecutive reads -> 16 consecutive rsp_valid cycles, data in order, no bubbles.
- DEPTH=10: write 0x55 to addr 12, then read addr 12 -> rsp_data=0, rsp_err=1; read addr 9 -> rsp_err=0.
- After data is loaded, pulse clear for one cycle with req_valid=1 (read addr 5) -> request not accepted that cycle, init_done low for 16 cycles; the held read is then accepted and returns 0.
- Assert reset_n=0 at INIT cycle 7 -> INIT restarts, init_done rises exactly 16 cycles after reset release, all reads return INIT_VALUE.
